// File: rtl/bin_frame_tx_pkg.sv
// bin_frame_tx_pkg: shared constants, state type and pixel helpers for the binary frame transmitter
package bin_frame_tx_pkg;
  localparam int WIDTH = 3;
  localparam int HEIGHT = 3;
  localparam int PIX_BITS = 8;
  localparam int FRAME_BITS = WIDTH * HEIGHT * PIX_BITS;
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  localparam int RW = HEIGHT > 1 ? $clog2(HEIGHT) : 1;
  typedef enum logic {IDLE, SEND} state_t;
  typedef logic [0:FRAME_BITS-1] frame_t;
  function automatic logic pix_of(frame_t f, int unsigned p);
    return |f[p*PIX_BITS +: PIX_BITS];
  endfunction
  function automatic logic byte_ok(logic [PIX_BITS-1:0] b);
    return b == '0 || b == '1;
  endfunction
endpackage

// File: rtl/bin_frame_tx_if.sv
// bin_frame_tx_if: frame input handshake, pixel output stream and status of the transmitter
interface bin_frame_tx_if;
  import bin_frame_tx_pkg::*;
  logic in_valid;
  logic in_ready;
  frame_t in_frame;
  logic out_valid;
  logic out_ready;
  logic out_pix;
  logic out_eol;
  logic out_eof;
  logic fmt_err;
  logic busy;
  modport slave (
    input in_valid, in_frame, out_ready,
    output in_ready, out_valid, out_pix, out_eol, out_eof, fmt_err, busy
  );
  modport master (
    output in_valid, in_frame, out_ready,
    input in_ready, out_valid, out_pix, out_eol, out_eof, fmt_err, busy
  );
endinterface

// File: rtl/bin_frame_fmt_check.sv
// bin_frame_fmt_check: flags a frame holding any byte that is neither all-zero nor all-one
module bin_frame_fmt_check
  import bin_frame_tx_pkg::*;
(
  input  frame_t frame,
  output logic   mixed
);
  always_comb begin
    mixed = 1'b0;
    for (int i = 0; i < WIDTH * HEIGHT; i++) mixed |= !byte_ok(frame[i*PIX_BITS +: PIX_BITS]);
  end
endmodule

// File: rtl/bin_frame_tx.sv
// bin_frame_tx: double-buffered transmitter streaming binarized frames one pixel per beat, row-major
module bin_frame_tx
  import bin_frame_tx_pkg::*;
(
  input logic clk,
  input logic rst_n,
  bin_frame_tx_if.slave b
);
  state_t state;
  frame_t act, pend;
  logic pend_v, fmt_err, mixed, eol, last_row, acc, fire;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  bin_frame_fmt_check u_chk (.frame(b.in_frame), .mixed(mixed));
  assign eol = col == CW'(WIDTH - 1);
  assign last_row = row == RW'(HEIGHT - 1);
  assign acc = b.in_valid && !pend_v;
  assign fire = state == SEND && b.out_ready;
  assign b.in_ready = !pend_v;
  assign b.out_valid = state == SEND;
  assign b.out_pix = state == SEND && pix_of(act, int'(row) * WIDTH + int'(col));
  assign b.out_eol = state == SEND && eol;
  assign b.out_eof = b.out_eol && last_row;
  assign b.fmt_err = fmt_err;
  assign b.busy = state == SEND || pend_v;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      act <= '0;
      pend <= '0;
      pend_v <= 1'b0;
      col <= '0;
      row <= '0;
      fmt_err <= 1'b0;
    end else begin
      if (acc && mixed) fmt_err <= 1'b1;
      if (state == IDLE) begin
        if (acc) begin
          act <= b.in_frame;
          col <= '0;
          row <= '0;
          state <= SEND;
        end
      end else begin
        // an accept landing on the final beat with pending empty bypasses pending
        if (acc && !(fire && eol && last_row)) begin
          pend <= b.in_frame;
          pend_v <= 1'b1;
        end
        if (fire) begin
          col <= eol ? '0 : col + 1'b1;
          if (eol) row <= last_row ? '0 : row + 1'b1;
          if (eol && last_row) begin
            if (pend_v) begin
              act <= pend;
              pend_v <= 1'b0;
            end else if (acc) act <= b.in_frame;
            else state <= IDLE;
          end
        end
      end
    end
  end
endmodule
